// File: rtl/opsum_collector.sv
// Psum row collector: buffers up to DEPTH psums from the PE, accumulates them over
// several channel passes, then drains the row through ReLU / shift / int8 saturation.
module opsum_collector #(
    parameter int DEPTH  = 16,
    parameter int PSUM_W = 24,
    parameter int OUT_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start,
    input  logic [$clog2(DEPTH+1)-1:0]   cfg_len,
    input  logic [3:0]                   cfg_pass,
    input  logic [4:0]                   cfg_shift,
    input  logic                         cfg_relu,
    output logic                         cfg_err,
    input  logic                         opsum_enable,
    input  logic signed [PSUM_W-1:0]     opsum_noc,
    output logic                         opsum_ready,
    output logic                         ofmap_valid,
    output logic [OUT_W-1:0]             ofmap_data,
    input  logic                         ofmap_ready,
    output logic                         busy,
    output logic                         done
);

    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic signed [PSUM_W-1:0] Q_MAX = PSUM_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [PSUM_W-1:0] Q_MIN = ~Q_MAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN
    } state_e;

    state_e                   state_q;
    logic [LEN_W-1:0]         len_q;
    logic [3:0]               pass_q;
    logic [4:0]               shift_q;
    logic                     relu_q;
    logic [IDX_W-1:0]         idx_q;
    logic [3:0]               pass_cnt_q;
    logic                     cfg_err_q;
    logic                     done_q;
    logic signed [PSUM_W-1:0] buf_q [DEPTH];

    logic                     cfg_ok;
    logic                     idx_last;
    logic                     pass_last;
    logic                     acc_fire;
    logic                     drain_fire;
    logic signed [PSUM_W-1:0] buf_d;
    logic signed [PSUM_W-1:0] rd_val;
    logic signed [PSUM_W-1:0] relu_val;
    logic signed [PSUM_W-1:0] shifted;
    logic [OUT_W-1:0]         quant;

    assign cfg_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(DEPTH)) && (cfg_pass != '0);
    assign idx_last   = (LEN_W'(idx_q) == len_q - LEN_W'(1));
    assign pass_last  = (pass_cnt_q == pass_q - 4'd1);
    assign acc_fire   = (state_q == S_ACC) && opsum_enable;
    assign drain_fire = (state_q == S_DRAIN) && ofmap_ready;

    // First pass overwrites, so stale contents from a previous row never leak in.
    assign buf_d = (pass_cnt_q == '0) ? opsum_noc : buf_q[idx_q] + opsum_noc;

    // NOTE: every variable gets a value on every path through always_comb, otherwise a latch is inferred.
    always_comb begin
        rd_val   = buf_q[idx_q];
        relu_val = (relu_q && rd_val[PSUM_W-1]) ? '0 : rd_val;
        shifted  = relu_val >>> shift_q;
        quant    = shifted[OUT_W-1:0];
        if (shifted > Q_MAX) begin
            quant = Q_MAX[OUT_W-1:0];
        end else if (shifted < Q_MIN) begin
            quant = Q_MIN[OUT_W-1:0];
        end
    end

    // NOTE: the buffer has no reset on purpose; it is a plain RAM and pass 0 rewrites every used entry.
    always_ff @(posedge clk) begin
        if (acc_fire) begin
            buf_q[idx_q] <= buf_d;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            pass_q     <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            idx_q      <= '0;
            pass_cnt_q <= '0;
            cfg_err_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg_start) begin
                        if (cfg_ok) begin
                            len_q      <= cfg_len;
                            pass_q     <= cfg_pass;
                            shift_q    <= cfg_shift;
                            relu_q     <= cfg_relu;
                            idx_q      <= '0;
                            pass_cnt_q <= '0;
                            state_q    <= S_ACC;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                S_ACC: begin
                    if (acc_fire) begin
                        if (idx_last) begin
                            idx_q <= '0;
                            if (pass_last) begin
                                pass_cnt_q <= '0;
                                state_q    <= S_DRAIN;
                            end else begin
                                pass_cnt_q <= pass_cnt_q + 4'd1;
                            end
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_fire) begin
                        if (idx_last) begin
                            idx_q   <= '0;
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign opsum_ready = (state_q == S_ACC);
    assign ofmap_valid = (state_q == S_DRAIN);
    assign ofmap_data  = (state_q == S_DRAIN) ? quant : '0;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_opsum_collector.sv
// Directed bench for opsum_collector: a table of row configurations with hand-computed
// ofmap values, plus sequences for back-pressure, illegal config and mid-run reset.
module tb_opsum_collector;

    logic              clk;
    logic              rst;
    logic              cfg_start;
    logic [4:0]        cfg_len;
    logic [3:0]        cfg_pass;
    logic [4:0]        cfg_shift;
    logic              cfg_relu;
    logic              cfg_err;
    logic              opsum_enable;
    logic [23:0]       opsum_noc;
    logic              opsum_ready;
    logic              ofmap_valid;
    logic [7:0]        ofmap_data;
    logic              ofmap_ready;
    logic              busy;
    logic              done;

    opsum_collector #(.DEPTH(16), .PSUM_W(24), .OUT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (cfg_start),
        .cfg_len      (cfg_len),
        .cfg_pass     (cfg_pass),
        .cfg_shift    (cfg_shift),
        .cfg_relu     (cfg_relu),
        .cfg_err      (cfg_err),
        .opsum_enable (opsum_enable),
        .opsum_noc    (opsum_noc),
        .opsum_ready  (opsum_ready),
        .ofmap_valid  (ofmap_valid),
        .ofmap_data   (ofmap_data),
        .ofmap_ready  (ofmap_ready),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]        len;
        logic [3:0]        pass;
        logic [4:0]        shift;
        logic              relu;
        logic [15:0][23:0] psum;
        logic [15:0][7:0]  expv;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic row(input int r, input int len, input int pass, input int shift, input int relu);
        vecs[r].len   = 5'(len);
        vecs[r].pass  = 4'(pass);
        vecs[r].shift = 5'(shift);
        vecs[r].relu  = 1'(relu);
        vecs[r].psum  = '0;
        vecs[r].expv  = '0;
    endtask

    task automatic ps(input int r, input int i, input int p);
        vecs[r].psum[i] = 24'(p);
    endtask

    task automatic ex(input int r, input int i, input int e);
        vecs[r].expv[i] = 8'(e);
    endtask

    task automatic do_cfg(input int len, input int pass, input int shift, input int relu);
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_len   = 5'(len);
        cfg_pass  = 4'(pass);
        cfg_shift = 5'(shift);
        cfg_relu  = 1'(relu);
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic send(input int r, input int from, input int to);
        for (int i = from; i < to; i++) begin
            opsum_noc    = vecs[r].psum[i];
            opsum_enable = 1'b1;
            check("opsum_ready_acc", opsum_ready, 1);
            @(negedge clk);
        end
        opsum_enable = 1'b0;
    endtask

    task automatic collect(input int r, input int stall_at);
        for (int j = 0; j < int'(vecs[r].len); j++) begin
            if (j == stall_at) begin
                ofmap_ready  = 1'b0;
                opsum_enable = 1'b1;
                opsum_noc    = 24'd77;
                for (int k = 0; k < 3; k++) begin
                    check("stall_valid", ofmap_valid, 1);
                    check("stall_data", $signed(ofmap_data), $signed(vecs[r].expv[j]));
                    check("stall_opsum_ready", opsum_ready, 0);
                    @(negedge clk);
                end
                opsum_enable = 1'b0;
            end
            ofmap_ready = 1'b1;
            check("ofmap_valid", ofmap_valid, 1);
            check("ofmap_data", $signed(ofmap_data), $signed(vecs[r].expv[j]));
            @(negedge clk);
        end
        check("done_rise", done, 1);
        check("busy_fall", busy, 0);
        check("valid_after_row", ofmap_valid, 0);
        ofmap_ready = 1'b0;
        @(negedge clk);
        check("done_pulse_end", done, 0);
    endtask

    task automatic run_vec(input int r, input int stall_at);
        do_cfg(int'(vecs[r].len), int'(vecs[r].pass), int'(vecs[r].shift), int'(vecs[r].relu));
        check("busy_acc", busy, 1);
        send(r, 0, int'(vecs[r].len) * int'(vecs[r].pass));
        check("first_valid_latency", ofmap_valid, 1);
        collect(r, stall_at);
    endtask

    initial begin
        rst          = 1'b1;
        cfg_start    = 1'b0;
        cfg_len      = '0;
        cfg_pass     = '0;
        cfg_shift    = '0;
        cfg_relu     = 1'b0;
        opsum_enable = 1'b0;
        opsum_noc    = '0;
        ofmap_ready  = 1'b0;

        row(0, 4, 1, 0, 0);
        ps(0, 0, 2);   ps(0, 1, -22); ps(0, 2, 19);  ps(0, 3, 18);
        ex(0, 0, 2);   ex(0, 1, -22); ex(0, 2, 19);  ex(0, 3, 18);
        row(1, 4, 2, 1, 1);
        ps(1, 0, 2);   ps(1, 1, -22); ps(1, 2, 19);  ps(1, 3, 18);
        ps(1, 4, -20); ps(1, 5, -18); ps(1, 6, 4);   ps(1, 7, 41);
        ex(1, 0, 0);   ex(1, 1, 0);   ex(1, 2, 11);  ex(1, 3, 29);
        row(2, 3, 1, 0, 0);
        ps(2, 0, 300); ps(2, 1, -300); ps(2, 2, 100);
        ex(2, 0, 127); ex(2, 1, -128); ex(2, 2, 100);
        row(3, 3, 1, 2, 0);
        ps(3, 0, 300); ps(3, 1, -300); ps(3, 2, 100);
        ex(3, 0, 75);  ex(3, 1, -75);  ex(3, 2, 25);
        // 8388607 + 1 wraps to -8388608 in 24 bits; 3000 >>> 4 = 187 saturates.
        row(4, 2, 3, 4, 0);
        ps(4, 0, 8388607); ps(4, 1, 1000); ps(4, 2, 1); ps(4, 3, 1000);
        ps(4, 4, 0);       ps(4, 5, 1000);
        ex(4, 0, -128);    ex(4, 1, 127);
        row(5, 3, 1, 23, 0);
        ps(5, 0, -8388608); ps(5, 1, 8388607); ps(5, 2, -1);
        ex(5, 0, -1);       ex(5, 1, 0);       ex(5, 2, -1);
        row(6, 2, 1, 1, 0);
        ps(6, 0, -3);  ps(6, 1, -258);
        ex(6, 0, -2);  ex(6, 1, -128);
        // Full 16-entry row, psum = 20*i - 150, ReLU on, no shift.
        row(7, 16, 1, 0, 1);
        for (int i = 0; i < 16; i++) begin
            ps(7, i, 20 * i - 150);
            ex(7, i, (20 * i - 150 < 0) ? 0 : (20 * i - 150 > 127) ? 127 : 20 * i - 150);
        end

        #3 rst = 1'b0;
        #1;
        check("rst_opsum_ready", opsum_ready, 0);
        check("rst_ofmap_valid", ofmap_valid, 0);
        check("rst_ofmap_data", $signed(ofmap_data), 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int r = 0; r < NVEC; r++) begin
            run_vec(r, -1);
        end

        // Back-pressure in DRAIN with the producer still asserting enable.
        run_vec(0, 2);

        // Illegal configurations.
        do_cfg(0, 1, 0, 0);
        check("err_len0", cfg_err, 1);
        check("err_len0_busy", busy, 0);
        @(negedge clk);
        check("err_len0_pulse_end", cfg_err, 0);
        do_cfg(4, 0, 0, 0);
        check("err_pass0", cfg_err, 1);
        check("err_pass0_busy", busy, 0);
        @(negedge clk);
        check("err_pass0_pulse_end", cfg_err, 0);
        do_cfg(17, 1, 0, 0);
        check("err_len17", cfg_err, 1);
        check("err_len17_busy", busy, 0);
        @(negedge clk);

        // cfg_start mid-ACC must not disturb the row in progress.
        do_cfg(4, 1, 0, 0);
        send(0, 0, 2);
        do_cfg(1, 1, 5, 1);
        check("midacc_no_err", cfg_err, 0);
        check("midacc_busy", busy, 1);
        send(0, 2, 4);
        check("midacc_valid", ofmap_valid, 1);
        collect(0, -1);

        // Asynchronous reset mid-row, then a clean rerun.
        do_cfg(4, 1, 0, 0);
        send(0, 0, 2);
        #2 rst = 1'b0;
        #1;
        check("arst_opsum_ready", opsum_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_ofmap_valid", ofmap_valid, 0);
        check("arst_ofmap_data", $signed(ofmap_data), 0);
        check("arst_done", done, 0);
        check("arst_cfg_err", cfg_err, 0);
        @(negedge clk);
        check("arst_no_done", done, 0);
        rst = 1'b1;
        @(negedge clk);
        run_vec(0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
